// File: rtl/sram_ctrl.sv
// sram_ctrl - single-port controller for an external asynchronous SRAM.
//
// Takes one read or write request at a time over a ready/valid style
// handshake and sequences CE_n/OE_n/WE_n, address and data pins through
// IDLE -> SETUP -> STROBE (WAIT_CYCLES) -> HOLD -> IDLE. The bidirectional
// DQ bus is split into o_sram_dq / o_sram_dq_oe / i_sram_dq for the pad
// wrapper. Every output comes straight from a flop.
//
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_req, i_we         request strobe, 1 = write (sampled at accept)
//   i_addr, i_wdata     word address, write data (sampled at accept)
//   o_ready             high only in IDLE
//   o_rvalid, o_rdata   one-cycle read-complete pulse, last read data
//   o_sram_addr         SRAM address pins
//   o_sram_dq(_oe)      data toward SRAM and its pad drive enable
//   i_sram_dq           data from SRAM pads
//   o_sram_ce_n/oe_n/we_n  active-low SRAM strobes
//   o_led               heartbeat LED
//
// Compile-time option: define SRAM_CTRL_HEARTBEAT_EN to build a CBITS-bit
// free-running counter whose MSB drives o_led; otherwise o_led is tied low.

module sram_ctrl #(
  parameter int AW          = 20,
  parameter int DW          = 8,
  parameter int WAIT_CYCLES = 2,
  parameter int CBITS       = 25
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic          o_ready,
  output logic          o_rvalid,
  output logic [DW-1:0] o_rdata,
  output logic [AW-1:0] o_sram_addr,
  output logic [DW-1:0] o_sram_dq,
  output logic          o_sram_dq_oe,
  input  logic [DW-1:0] i_sram_dq,
  output logic          o_sram_ce_n,
  output logic          o_sram_oe_n,
  output logic          o_sram_we_n,
  output logic          o_led
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  // Strobe counter reload: counts WAIT_CYCLES-1 down to 0 across STROBE.
  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ready_q, ready_d;
  logic          rvalid_q, rvalid_d;
  logic          dq_oe_q, dq_oe_d;
  logic          ce_n_q, ce_n_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      S_IDLE: begin
        if (i_req && ready_q) begin
          state_d = S_SETUP;
          we_d    = i_we;
          addr_d  = i_addr;
          wdata_d = i_wdata;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
        cnt_d   = CNT_LOAD;
      end
      S_STROBE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_HOLD;
          // Last STROBE edge: OE_n has been low for WAIT_CYCLES cycles.
          if (!we_q) begin
            rdata_d = i_sram_dq;
          end else begin
            rdata_d = rdata_q;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HOLD: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are decoded from the upcoming state so they are registered
    // alongside it; address/data only change on accept, never mid-strobe.
    ready_d  = (state_d == S_IDLE);
    ce_n_d   = (state_d == S_IDLE);
    oe_n_d   = !((state_d == S_STROBE) && !we_d);
    we_n_d   = !((state_d == S_STROBE) && we_d);
    dq_oe_d  = (state_d != S_IDLE) && we_d;
    rvalid_d = (state_d == S_HOLD) && !we_d;
  end

  // State, transaction latches and output registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      dq_oe_q  <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      dq_oe_q  <= dq_oe_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
    end
  end

  assign o_ready      = ready_q;
  assign o_rvalid     = rvalid_q;
  assign o_rdata      = rdata_q;
  assign o_sram_addr  = addr_q;
  assign o_sram_dq    = wdata_q;
  assign o_sram_dq_oe = dq_oe_q;
  assign o_sram_ce_n  = ce_n_q;
  assign o_sram_oe_n  = oe_n_q;
  assign o_sram_we_n  = we_n_q;

`ifdef SRAM_CTRL_HEARTBEAT_EN
  logic [CBITS-1:0] hb_q;

  // Free-running heartbeat counter; MSB toggles every 2^(CBITS-1) cycles.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hb_q <= '0;
    end else begin
      hb_q <= hb_q + {{(CBITS-1){1'b0}}, 1'b1};
    end
  end

  assign o_led = hb_q[CBITS-1];
`else
  // No counter in this build; the tie keeps CBITS referenced so both
  // builds share one parameter list.
  logic [CBITS-1:0] hb_tie_s;
  assign hb_tie_s = '0;
  assign o_led    = |hb_tie_s;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl (WAIT_CYCLES=2, CBITS=4) with a small
// behavioural SRAM model and directed transactions.
module tb_sram_ctrl;

  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req;
  logic        i_we;
  logic [19:0] i_addr;
  logic [7:0]  i_wdata;
  logic        o_ready;
  logic        o_rvalid;
  logic [7:0]  o_rdata;
  logic [19:0] o_sram_addr;
  logic [7:0]  o_sram_dq;
  logic        o_sram_dq_oe;
  logic [7:0]  sram_dq_in;
  logic        o_sram_ce_n;
  logic        o_sram_oe_n;
  logic        o_sram_we_n;
  logic        o_led;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem [0:1023];

  sram_ctrl #(
    .AW(20), .DW(8), .WAIT_CYCLES(WAIT), .CBITS(4)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_req        (i_req),
    .i_we         (i_we),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_ready      (o_ready),
    .o_rvalid     (o_rvalid),
    .o_rdata      (o_rdata),
    .o_sram_addr  (o_sram_addr),
    .o_sram_dq    (o_sram_dq),
    .o_sram_dq_oe (o_sram_dq_oe),
    .i_sram_dq    (sram_dq_in),
    .o_sram_ce_n  (o_sram_ce_n),
    .o_sram_oe_n  (o_sram_oe_n),
    .o_sram_we_n  (o_sram_we_n),
    .o_led        (o_led)
  );

  always #5 clk = ~clk;

  // SRAM model: asynchronous read, write while CE_n and WE_n are low.
  assign sram_dq_in = (!o_sram_ce_n && !o_sram_oe_n) ? mem[o_sram_addr[9:0]] : 8'h00;

  always @(posedge clk) begin
    if (!rst_n) begin
      mem[10'h345] <= 8'h3C;
    end else if (!o_sram_ce_n && !o_sram_we_n && o_sram_dq_oe) begin
      mem[o_sram_addr[9:0]] <= o_sram_dq;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from IDLE, checking every pin cycle by cycle.
  task automatic do_txn(input logic we, input logic [19:0] a, input logic [7:0] d,
                        input logic [7:0] exp_rd);
    i_req = 1'b1; i_we = we; i_addr = a; i_wdata = d;
    tick();
    // Scramble inputs: the transaction in flight must not see them.
    i_req = 1'b0; i_we = ~we; i_addr = ~a; i_wdata = ~d;
    check("setup_ready", o_ready, 0);
    check("setup_ce_n", o_sram_ce_n, 0);
    check("setup_strobes", {o_sram_oe_n, o_sram_we_n}, 2'b11);
    check("setup_dq_oe", o_sram_dq_oe, we);
    check("setup_addr", o_sram_addr, a);
    for (int c = 1; c <= WAIT + 1; c++) begin
      tick();
      check("addr_held", o_sram_addr, a);
      check("ce_n_low", o_sram_ce_n, 0);
      check("ready_low", o_ready, 0);
      if (we) begin
        check("wdata_held", o_sram_dq, d);
        check("dq_oe_wr", o_sram_dq_oe, 1);
      end else begin
        check("dq_oe_rd", o_sram_dq_oe, 0);
      end
      if (c <= WAIT) begin
        check("strobe_low", {o_sram_oe_n, o_sram_we_n}, we ? 2'b10 : 2'b01);
        check("rvalid_early", o_rvalid, 0);
      end else begin
        check("hold_strobes", {o_sram_oe_n, o_sram_we_n}, 2'b11);
        check("hold_rvalid", o_rvalid, !we);
        if (!we) begin
          check("rdata", o_rdata, exp_rd);
        end
      end
    end
    tick();
    check("idle_ready", o_ready, 1);
    check("idle_ce_n", o_sram_ce_n, 1);
    check("idle_dq_oe", o_sram_dq_oe, 0);
    check("idle_rvalid", o_rvalid, 0);
    if (!we) begin
      check("rdata_kept", o_rdata, exp_rd);
    end
  endtask

  initial begin
    rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_addr = 20'h0; i_wdata = 8'h0;
    tick();
    tick();
    // Reset values.
    check("rst_ready", o_ready, 1);
    check("rst_rvalid", o_rvalid, 0);
    check("rst_rdata", o_rdata, 0);
    check("rst_addr", o_sram_addr, 0);
    check("rst_dq", o_sram_dq, 0);
    check("rst_dq_oe", o_sram_dq_oe, 0);
    check("rst_ce_n", o_sram_ce_n, 1);
    check("rst_oe_n", o_sram_oe_n, 1);
    check("rst_we_n", o_sram_we_n, 1);
    rst_n = 1'b1;

    // Heartbeat: with CBITS=4, low 8 cycles then high 8 cycles.
    for (int i = 0; i < 16; i++) begin
`ifdef SRAM_CTRL_HEARTBEAT_EN
      check("led_hb", o_led, (i >= 8) ? 1 : 0);
`else
      check("led_off", o_led, 0);
`endif
      tick();
    end

    // Read preloaded word, write over it, read back.
    do_txn(1'b0, 20'h12345, 8'h00, 8'h3C);
    do_txn(1'b1, 20'h12345, 8'hA5, 8'h00);
    do_txn(1'b0, 20'h12345, 8'h00, 8'hA5);

    // Back-to-back with i_req held high.
    i_req = 1'b1; i_we = 1'b1; i_addr = 20'h00001; i_wdata = 8'h11;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("b2b_ready", o_ready, (k == 4) ? 1 : 0);
    end
    check("b2b_gap_ce_n", o_sram_ce_n, 1);
    i_we = 1'b0;
    tick();
    check("b2b_accept", o_ready, 0);
    check("b2b_rd_addr", o_sram_addr, 20'h00001);
    check("b2b_rd_dq_oe", o_sram_dq_oe, 0);
    i_req = 1'b0;
    tick();
    tick();
    tick();
    check("b2b_rvalid", o_rvalid, 1);
    check("b2b_rdata", o_rdata, 8'h11);
    tick();
    check("b2b_done", o_ready, 1);

    // Request during STROBE is ignored.
    i_req = 1'b1; i_we = 1'b1; i_addr = 20'h00200; i_wdata = 8'h77;
    tick();
    i_req = 1'b0;
    tick();
    i_req = 1'b1; i_we = 1'b0; i_addr = 20'h00300;
    tick();
    check("ign_addr", o_sram_addr, 20'h00200);
    check("ign_we_n", o_sram_we_n, 0);
    check("ign_oe_n", o_sram_oe_n, 1);
    i_req = 1'b0;
    tick();
    check("ign_rvalid", o_rvalid, 0);
    tick();
    check("ign_ready", o_ready, 1);
    tick();
    check("ign_no_txn", o_ready, 1);
    check("ign_ce_n", o_sram_ce_n, 1);
    check("ign_addr_after", o_sram_addr, 20'h00200);
    check("ign_mem", mem[10'h200], 8'h77);

    // Reset in the middle of a write strobe.
    i_req = 1'b1; i_we = 1'b1; i_addr = 20'h00400; i_wdata = 8'h55;
    tick();
    i_req = 1'b0;
    tick();
    check("mid_we_n_low", o_sram_we_n, 0);
    rst_n = 1'b0;
    tick();
    check("mid_rst_we_n", o_sram_we_n, 1);
    check("mid_rst_ce_n", o_sram_ce_n, 1);
    check("mid_rst_dq_oe", o_sram_dq_oe, 0);
    check("mid_rst_ready", o_ready, 1);
    check("mid_rst_rvalid", o_rvalid, 0);
    check("mid_rst_addr", o_sram_addr, 0);
    rst_n = 1'b1;
    tick();
    check("post_rst_ready", o_ready, 1);
    check("post_rst_rvalid", o_rvalid, 0);
    check("post_rst_ce_n", o_sram_ce_n, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Single-port controller for an external asynchronous SRAM (default 1M x 8), parametrised in address width, data width and strobe length. It takes one read or write request at a time from on-chip logic over a ready/valid handshake and sequences the SRAM chip-enable, output-enable, write-enable, address and data pins. A compile-time heartbeat LED counter is retained for board bring-up. The block sits between the user logic and the top-level pad/tristate wrapper; the bidirectional DQ bus is split into in/out/enable signals here.

## Interface
- AW, 20: address width; SRAM has 2^AW words.
- DW, 8: data width.
- WAIT_CYCLES, 2: clock cycles the OE_n/WE_n strobe is held low; legal range 1..15.
- CBITS, 25: heartbeat counter width.
- i_clk  in  1  system clock; all logic on its rising edge.
- i_rst_n  in  1  synchronous reset, active low.
- i_req  in  1  request strobe; accepted on an edge where i_req && o_ready.
- i_we  in  1  1 = write, 0 = read; sampled at accept.
- i_addr  in  AW  word address; sampled at accept.
- i_wdata  in  DW  write data; sampled at accept.
- o_ready  out  1  high only in IDLE.
- o_rvalid  out  1  one-cycle pulse: o_rdata holds new read data.
- o_rdata  out  DW  last read data; holds until next read completes.
- o_sram_addr  out  AW  SRAM address pins.
- o_sram_dq  out  DW  data driven toward SRAM.
- o_sram_dq_oe  out  1  1 = pad wrapper drives o_sram_dq onto DQ.
- i_sram_dq  in  DW  data from SRAM DQ pads.
- o_sram_ce_n  out  1  chip enable, active low.
- o_sram_oe_n  out  1  output enable, active low.
- o_sram_we_n  out  1  write enable, active low.
- o_led  out  1  heartbeat (see Configuration).

## Operation
- All outputs registered. Reset values: o_ready 1, o_rvalid 0, o_rdata 0, o_sram_addr 0, o_sram_dq 0, o_sram_dq_oe 0, o_sram_ce_n 1, o_sram_oe_n 1, o_sram_we_n 1, o_led 0; state IDLE, wait counter 0.
- States: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE: strobes high, dq_oe 0. On accept, latch i_we/i_addr/i_wdata, go SETUP. Without accept, stay.
- SETUP (1 cycle): address valid, ce_n 0, oe_n/we_n 1; dq_oe = latched we, o_sram_dq = latched wdata.
- STROBE (WAIT_CYCLES cycles): ce_n 0; read: oe_n 0; write: we_n 0, dq_oe 1. Counter loads WAIT_CYCLES-1 on entry, decrements; leave at 0. Read: i_sram_dq captured into o_rdata on the final STROBE edge.
- HOLD (1 cycle): oe_n/we_n 1, ce_n 0, address and write data/dq_oe still held (hold time); read: o_rvalid 1.
- Returning to IDLE: ce_n 1, dq_oe 0, o_ready 1.
- i_req while o_ready=0 is ignored (no queue, no error); requester must hold i_req until accepted.
- Input changes after accept have no effect on the transaction in flight.
- Address, data and dq_oe never change while oe_n or we_n is low.
- Reset asserted mid-transaction: on that edge all outputs take reset values (strobes released, dq_oe 0); transaction discarded, no o_rvalid.

## Timing
- Accept at edge E0. SETUP cycle follows E0; strobe low from E1 to E1+WAIT_CYCLES; HOLD from E1+WAIT_CYCLES; o_rvalid high for the cycle after edge E2+WAIT_CYCLES-1, i.e. WAIT_CYCLES+2 cycles after E0.
- o_ready rises at edge E0+WAIT_CYCLES+2; transaction period WAIT_CYCLES+3 cycles; next accept earliest on that edge's following edge.
- Read data sampled WAIT_CYCLES-1 cycles after oe_n falls plus one clock (i.e. at the edge ending the last STROBE cycle); tAA of SRAM must fit in (WAIT_CYCLES+1) clock periods.

## Configuration
- SRAM_CTRL_HEARTBEAT_EN defined: CBITS-bit free-running counter increments every cycle from 0 after reset; o_led = counter[CBITS-1] (period 2^CBITS cycles).
- Not defined: no counter synthesised; o_led constant 0. SRAM behaviour identical either way.

## Test plan
- Write: WAIT_CYCLES=2, req we=1 addr 0x12345 wdata 0xA5 -> SETUP 1 cycle, we_n low exactly 2 cycles, dq_oe 1 from SETUP through HOLD, addr/dq stable throughout, o_ready back 4 cycles after accept, oe_n never low.
- Read: model returns 0x3C at 0x12345 -> oe_n low 2 cycles, o_rvalid single pulse 4 cycles after accept with o_rdata 0x3C, dq_oe 0 throughout; o_rdata stays 0x3C afterward.
- Back-to-back: i_req held high for write 0x00001/0x11 then read 0x00001 -> second accepted on first o_ready edge, read returns 0x11; period 5 cycles each.
- Ignored request: pulse i_req during STROBE with different address -> no extra transaction, SRAM pins unchanged.
- Reset mid-write: drop i_rst_n during STROBE -> next edge we_n 1, ce_n 1, dq_oe 0, o_ready 1, no o_rvalid.
- Heartbeat: SRAM_CTRL_HEARTBEAT_EN with CBITS=4 -> o_led low 8 cycles, high 8 cycles after reset; without macro o_led stays 0.
